// File: rtl/tandy_kb_pkg.sv
// Shared Tandy-to-XT keyboard definitions.
// Holds the E0 prefix byte, the Tandy and XT key codes that differ between
// the two keyboards, the expander FSM state type and the mapping function.
// The receive-side converter uses the same table, so both directions stay
// consistent.
package tandy_kb_pkg;

   localparam logic [7:0] XT_PREFIX_E0     = 8'hE0;
   localparam int         TANDY_FIFO_DEPTH = 4;

   // Tandy key codes that need translation
   localparam logic [6:0] TANDY_KEY_UP       = 7'h29;
   localparam logic [6:0] TANDY_KEY_LEFT     = 7'h2B;
   localparam logic [6:0] TANDY_KEY_DOWN     = 7'h4A;
   localparam logic [6:0] TANDY_KEY_RIGHT    = 7'h4E;
   localparam logic [6:0] TANDY_KEY_KP_ENTER = 7'h57;
   localparam logic [6:0] TANDY_KEY_HOME     = 7'h58;
   localparam logic [6:0] TANDY_KEY_KP_MINUS = 7'h53;
   localparam logic [6:0] TANDY_KEY_KP_PLUS  = 7'h55;
   localparam logic [6:0] TANDY_KEY_DEL      = 7'h56;
   localparam logic [6:0] TANDY_KEY_F11      = 7'h59;
   localparam logic [6:0] TANDY_KEY_F12      = 7'h5A;

   // XT set-1 make codes they translate to
   localparam logic [6:0] XT_KEY_UP       = 7'h48;
   localparam logic [6:0] XT_KEY_LEFT     = 7'h4B;
   localparam logic [6:0] XT_KEY_DOWN     = 7'h50;
   localparam logic [6:0] XT_KEY_RIGHT    = 7'h4D;
   localparam logic [6:0] XT_KEY_KP_ENTER = 7'h1C;
   localparam logic [6:0] XT_KEY_HOME     = 7'h47;
   localparam logic [6:0] XT_KEY_KP_MINUS = 7'h4A;
   localparam logic [6:0] XT_KEY_KP_PLUS  = 7'h4E;
   localparam logic [6:0] XT_KEY_DEL      = 7'h53;
   localparam logic [6:0] XT_KEY_F11      = 7'h57;
   localparam logic [6:0] XT_KEY_F12      = 7'h58;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PRESENT  = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_GAP      = 2'd3
   } exp_state_t;

   // ext: the XT byte must be preceded by the E0 prefix
   typedef struct packed {
      logic       ext;
      logic [6:0] key;
   } xt_map_t;

   function automatic xt_map_t tandy_to_xt(input logic [6:0] key);
      xt_map_t m;
      m.ext = 1'b0;
      m.key = key;
      case (key)
         TANDY_KEY_UP:       begin m.ext = 1'b1; m.key = XT_KEY_UP;       end
         TANDY_KEY_LEFT:     begin m.ext = 1'b1; m.key = XT_KEY_LEFT;     end
         TANDY_KEY_DOWN:     begin m.ext = 1'b1; m.key = XT_KEY_DOWN;     end
         TANDY_KEY_RIGHT:    begin m.ext = 1'b1; m.key = XT_KEY_RIGHT;    end
         TANDY_KEY_KP_ENTER: begin m.ext = 1'b1; m.key = XT_KEY_KP_ENTER; end
         TANDY_KEY_HOME:     begin m.ext = 1'b1; m.key = XT_KEY_HOME;     end
         TANDY_KEY_KP_MINUS: m.key = XT_KEY_KP_MINUS;
         TANDY_KEY_KP_PLUS:  m.key = XT_KEY_KP_PLUS;
         TANDY_KEY_DEL:      m.key = XT_KEY_DEL;
         TANDY_KEY_F11:      m.key = XT_KEY_F11;
         TANDY_KEY_F12:      m.key = XT_KEY_F12;
         default:            m.key = key;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/tandy_code_fifo.sv
// Small synchronous FIFO of Tandy codes.
// Ports: clock, reset (async, active high), push/din write side,
// pop/dout read side (dout shows the head entry), empty, full.
// Push while full and pop while empty are ignored. DEPTH must be a power
// of two.
module tandy_code_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign do_wr = push && !full;
   assign do_rd = pop && !empty;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/tandy_scancode_expander.sv
// Tandy keyboard code to XT set-1 scancode expander.
// Accepts Tandy codes (bit7 = break) on a valid/ready port and presents the
// translated XT bytes one at a time on scancode/keybord_irq, waiting for a
// host acknowledge (irq_clear) and then at least GAP_CYCLES idle cycles
// before the next byte. Extended keys produce E0 followed by the XT code.
// Ports: clock, reset (async, active high), tandy_code/tandy_valid/
// tandy_ready input side, scancode/keybord_irq/irq_clear host side,
// overflow (sticky, a code was offered while tandy_ready was low).
// Build option: define TANDY_EXPANDER_FIFO_EN for a 4-entry code FIFO;
// otherwise a single holding register is used.
//
// state    | meaning
// IDLE     | waiting for a queued code
// PRESENT  | load scancode and raise keybord_irq
// WAIT_ACK | byte visible, waiting for irq_clear
// GAP      | enforced idle time before the next byte
module tandy_scancode_expander
   import tandy_kb_pkg::*;
#(
   parameter int GAP_CYCLES = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tandy_code,
   input  logic       tandy_valid,
   output logic       tandy_ready,
   output logic [7:0] scancode,
   output logic       keybord_irq,
   input  logic       irq_clear,
   output logic       overflow
);

   localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

   exp_state_t    state;
   exp_state_t    state_next;
   logic [GW-1:0] gap_cnt;
   logic          second_byte;
   logic          load_byte;
   logic          ack;
   logic          push;
   logic          pop;
   logic          q_valid;
   logic          q_full;
   logic [7:0]    q_code;
   xt_map_t       map;
   logic          more_pending;

   assign tandy_ready = !q_full;
   assign push        = tandy_valid && !q_full;

   // The head of the queue stays in place until its last byte is
   // acknowledged, so a code's bytes are never split by another code.
`ifdef TANDY_EXPANDER_FIFO_EN
   logic q_empty;

   tandy_code_fifo #(
      .WIDTH (8),
      .DEPTH (TANDY_FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .din   (tandy_code),
      .pop   (pop),
      .dout  (q_code),
      .empty (q_empty),
      .full  (q_full)
   );

   assign q_valid = !q_empty;
`else
   logic       hold_full;
   logic [7:0] hold_code;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_full <= 1'b0;
         hold_code <= 8'h00;
      end else if (pop) begin
         hold_full <= 1'b0;
      end else if (push) begin
         hold_full <= 1'b1;
         hold_code <= tandy_code;
      end
   end

   assign q_full  = hold_full;
   assign q_valid = hold_full;
   assign q_code  = hold_code;
`endif

   assign map          = tandy_to_xt(q_code[6:0]);
   assign more_pending = map.ext && !second_byte;
   assign pop          = ack && !more_pending;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      load_byte  = 1'b0;
      ack        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (q_valid && gap_cnt == '0) state_next = ST_PRESENT;
         end
         ST_PRESENT: begin
            load_byte  = 1'b1;
            state_next = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (irq_clear) begin
               ack        = 1'b1;
               state_next = ST_GAP;
            end
         end
         ST_GAP: begin
            // leave on the cycle the down-counter reaches terminal count
            if (gap_cnt <= GW'(1)) state_next = second_byte ? ST_PRESENT : ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scancode    <= 8'h00;
         keybord_irq <= 1'b0;
         overflow    <= 1'b0;
         gap_cnt     <= '0;
         second_byte <= 1'b0;
      end else begin
         if (tandy_valid && q_full) overflow <= 1'b1;
         if (load_byte) begin
            scancode    <= more_pending ? XT_PREFIX_E0 : {q_code[7], map.key};
            keybord_irq <= 1'b1;
         end
         if (ack) begin
            keybord_irq <= 1'b0;
            gap_cnt     <= GW'(GAP_CYCLES);
            second_byte <= more_pending;
         end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
         end
      end
   end

endmodule

// File: doc/tandy_scancode_expander.md
TANDY_SCANCODE_EXPANDER -- requirements
Module: tandy_scancode_expander

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16: minimum idle cycles with keybord_irq low between two presented bytes.
REQ-002 SHALL have port clock, input, 1: single clock for all logic.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port tandy_code, input, 8: Tandy code; bit7 is the break flag, bits[6:0] are the key.
REQ-005 SHALL have port tandy_valid, input, 1: tandy_code is offered this cycle.
REQ-006 SHALL have port tandy_ready, output, 1: code is accepted on a cycle where tandy_valid and tandy_ready are both high.
REQ-007 SHALL have port scancode, output, 8: XT set-1 byte presented to the host.
REQ-008 SHALL have port keybord_irq, output, 1: high while scancode holds an unacknowledged byte.
REQ-009 SHALL have port irq_clear, input, 1: host acknowledge pulse.
REQ-010 SHALL have port overflow, output, 1: sticky; a code was offered while tandy_ready was low.

Function
REQ-011 SHALL expand key bits[6:0] as follows: 29->E0,48; 2B->E0,4B; 4A->E0,50; 4E->E0,4D; 57->E0,1C; 58->E0,47; 53->4A; 55->4E; 56->53; 59->57; 5A->58.
REQ-011a SHALL pass every other key code unchanged as a single byte.
REQ-012 SHALL emit the E0 prefix as 8'hE0 exactly, with no break bit; the final byte SHALL carry tandy_code bit7.
REQ-013 SHALL implement the FSM states IDLE, PRESENT, WAIT_ACK and GAP.
REQ-013a IDLE->PRESENT when the queue is non-empty and the gap counter is 0.
REQ-013b PRESENT loads scancode, sets keybord_irq, then moves to WAIT_ACK.
REQ-013c WAIT_ACK->GAP on irq_clear.
REQ-013d GAP->PRESENT after GAP_CYCLES cycles if a second byte of the same code is pending; otherwise GAP->IDLE.
REQ-014 SHALL assert keybord_irq 2 cycles after the accepting edge when in IDLE with the gap counter at 0.
REQ-015 SHALL drop keybord_irq on the cycle after irq_clear is sampled high.
REQ-016 SHALL ignore irq_clear outside WAIT_ACK.
REQ-017 SHALL hold scancode stable from PRESENT until the next PRESENT, including through GAP.
REQ-018 SHALL present the two bytes of one code back-to-back and never interleave them with bytes of another code.
REQ-019 SHALL drive tandy_ready low whenever the queue is full; a simultaneous pop SHALL NOT make room in that same cycle.
REQ-020 SHALL set overflow when tandy_valid is high and tandy_ready is low, and SHALL discard that code.

Reset
REQ-021 SHALL, on reset, at any time including mid-sequence, force: scancode=8'h00, keybord_irq=0, overflow=0, tandy_ready=1, queue empty, FSM in IDLE, gap counter 0.
REQ-021a A pending second byte SHALL be lost on reset.

Configuration
REQ-022 SHALL use macro TANDY_EXPANDER_FIFO_EN.
REQ-022a When TANDY_EXPANDER_FIFO_EN is defined, the queue SHALL be a 4-entry FIFO of Tandy codes.
REQ-022b When TANDY_EXPANDER_FIFO_EN is undefined, the queue SHALL be a single holding register; tandy_ready SHALL be low from accept until the last byte of that code is acknowledged.

Structure
REQ-023 SHALL take the E0 prefix constant, the Tandy/XT key-code constants and the expansion mapping function from shared package tandy_kb_pkg, so the receive-side converter and this block share one table.
REQ-024 SHALL place the FIFO in sub-module tandy_code_fifo, instantiated only under TANDY_EXPANDER_FIFO_EN.

Verification
REQ-025 SHALL cover: offer 8'h29 while idle -> scancode=E0 with irq high 2 cycles later; after clear and 16 gap cycles -> scancode=48 with irq high.
REQ-026 SHALL cover: offer 8'hD6 (break of 56) -> single byte scancode=D3; irq drops 1 cycle after irq_clear; FSM returns to IDLE after the gap.
REQ-027 SHALL cover: offer 8'h1E -> scancode=1E, single byte, no prefix.
REQ-028 SHALL cover: with FIFO enabled, offer 5 codes with no acknowledge -> 5th code refused, tandy_ready=0, overflow=1; acknowledging drains the 4 codes in order.
REQ-029 SHALL cover: offer 8'hD7, assert reset after E0 is presented -> irq=0 and scancode=00 immediately; no byte 9C follows.
REQ-030 SHALL cover: irq_clear held high continuously -> exactly one acknowledge per byte, with the gap still enforced between bytes.
